// File: rtl/ringosc_meter_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
// Holds the FSM state enum, byte-select codes, ID byte and default sizes.
package ringosc_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam logic [1:0] SEL_LO   = 2'd0;
  localparam logic [1:0] SEL_HI   = 2'd1;
  localparam logic [1:0] SEL_STAT = 2'd2;
  localparam logic [1:0] SEL_ID   = 2'd3;

  localparam logic [7:0] ID_BYTE    = 8'hA5;
  localparam logic [7:0] UIO_OE_VAL = 8'h07;

  localparam int COUNT_W_DEF   = 16;
  localparam int GATE_BASE_DEF = 10;

endpackage

// File: rtl/ringosc_sync_edge.sv
// Two-flop synchronizer followed by a delay flop for rising-edge detect.
// din: async input; pulse: one-clk high when synchronized din rises.
module ringosc_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic s1_q, s2_q, dly_q;
  logic s1_d, s2_d, dly_d;

  always_comb begin
    s1_d  = din;
    s2_d  = s1_q;
    dly_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      dly_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      dly_q <= dly_d;
    end
  end

  assign pulse = s2_q & ~dly_q;

endmodule

// File: rtl/tt_um_mbkmicdec_ringosc_meter.sv
// Ring-oscillator frequency meter: gated, saturating edge counter.
// ui_in osc/start/cont/sel/gate in; uo_out byte; uio_out busy/done/ovf.
module tt_um_mbkmicdec_ringosc_meter
  import ringosc_meter_pkg::*;
#(
  parameter int COUNT_W   = COUNT_W_DEF,
  parameter int GATE_BASE = GATE_BASE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int TMR_W = GATE_BASE + 8;
  localparam logic [TMR_W-1:0] TMR_ONE = 1;
  localparam logic [COUNT_W-1:0] CNT_ONE = 1;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic       osc_pulse;
  logic       start_pulse;
  logic       cont;
  logic [1:0] sel;
  logic [2:0] gsel;

  assign cont = ui_in[2];
  assign sel  = ui_in[4:3];
  assign gsel = ui_in[7:5];

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in};

  ringosc_sync_edge u_osc (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ui_in[0]),
    .pulse (osc_pulse)
  );

  ringosc_sync_edge u_start (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ui_in[1]),
    .pulse (start_pulse)
  );

  state_t             state_q, state_d;
  logic [2:0]         gate_q, gate_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               ovf_run_q, ovf_run_d;
  logic [COUNT_W-1:0] result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [TMR_W-1:0]   tmr_end;
  logic               cnt_full;
  logic [COUNT_W-1:0] cnt_inc;
  logic               enter;

  assign tmr_end  = (TMR_ONE << (GATE_BASE + int'(gate_q)))
                  - TMR_ONE;
  assign cnt_full = (cnt_q == CNT_MAX);
  assign cnt_inc  = cnt_full ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    ovf_run_d = ovf_run_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    done_d    = done_q;
    busy_d    = (state_q == ST_COUNT);
    enter     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_pulse || (cont && done_q))
          enter = 1'b1;
      end
      ST_COUNT: begin
        tmr_d = tmr_q + TMR_ONE;
        if (osc_pulse) begin
          cnt_d     = cnt_inc;
          ovf_run_d = ovf_run_q | cnt_full;
        end
        if (tmr_q == tmr_end)
          state_d = ST_LATCH;
      end
      ST_LATCH: begin
        // an edge landing in the latch cycle still belongs here
        result_d = osc_pulse ? cnt_inc : cnt_q;
        ovf_d    = ovf_run_q | (osc_pulse & cnt_full);
        done_d   = 1'b1;
        if (cont) enter   = 1'b1;
        else      state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter) begin
      state_d   = ST_COUNT;
      gate_d    = gsel;
      tmr_d     = '0;
      cnt_d     = '0;
      ovf_run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gate_q    <= '0;
      tmr_q     <= '0;
      cnt_q     <= '0;
      ovf_run_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      ovf_run_q <= ovf_run_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  logic [15:0] res16;
  logic [7:0]  uo_mux;

  assign res16 = 16'(result_q);

  always_comb begin
    uo_mux = ID_BYTE;
    unique case (1'b1)
      (sel == SEL_LO):   uo_mux = res16[7:0];
      (sel == SEL_HI):   uo_mux = res16[15:8];
      (sel == SEL_STAT): uo_mux = {ovf_q, busy_q, done_q,
                                   2'b00, gate_q};
      default:           uo_mux = ID_BYTE;
    endcase
  end

  assign uo_out  = uo_mux;
  assign uio_out = {5'b0, ovf_q, done_q, busy_q};
  assign uio_oe  = UIO_OE_VAL;

endmodule
